// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the sequential barrel shifter: operation codes,
// controller states and a small width helper.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_ROR  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Width of a counter that indexes n stages (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_stage.sv
// One barrel-shifter stage: shifts by 2^idx when enabled, else passes through.
// Every stage weight is built from constant shifts and the one selected by idx
// is muxed out, so no variable shifter is inferred.
module shift_stage
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int IDX_W  = 2
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] data_shifted
);

    logic [STAGES-1:0][WIDTH-1:0] cand;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_weight
        localparam int AMT = 1 << gi;
        logic [WIDTH-1:0] sll_val;
        logic [WIDTH-1:0] sra_val;
        logic [WIDTH-1:0] ror_val;

        assign sll_val = {data[WIDTH-1-AMT:0], {AMT{1'b0}}};
        assign sra_val = {{AMT{data[WIDTH-1]}}, data[WIDTH-1:AMT]};
        assign ror_val = {data[AMT-1:0], data[WIDTH-1:AMT]};

        // The reserved operation leaves the operand untouched.
        assign cand[gi] = (op == OP_SLL) ? sll_val :
                          (op == OP_SRA) ? sra_val :
                          (op == OP_ROR) ? ror_val : data;
    end

    // Select the weight addressed by idx; a disabled stage is a pass-through.
    always_comb begin
        data_shifted = data;
        if (en) begin
            for (int i = 0; i < STAGES; i++) begin
                if (idx == IDX_W'(i)) begin
                    data_shifted = cand[i];
                end
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter controller: captures an operand, walks one shared shift
// stage through weights 2^(STAGES-1) down to 1 (one per cycle), then holds the
// result until the consumer acknowledges it.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STAGES-1:0] shamt,
    input  logic              ack,
    output logic              ready,
    output logic              busy,
    output logic              valid,
    output logic [WIDTH-1:0]  data_out,
    output logic              err
);

    localparam int CNT_W = idx_width(STAGES);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  work_reg, work_next;
    op_t               op_reg, op_next;
    logic [STAGES-1:0] shamt_reg, shamt_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [WIDTH-1:0]  stage_out;
    logic              accept;

    // The single stage is reused every SHIFT cycle, indexed by the counter.
    shift_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .IDX_W  (CNT_W)
    ) u_stage (
        .data         (work_reg),
        .op           (op_reg),
        .idx          (cnt_reg),
        .en           (shamt_reg[cnt_reg]),
        .data_shifted (stage_out)
    );

    // State and datapath registers; reset discards any shift in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            work_reg  <= '0;
            op_reg    <= OP_SLL;
            shamt_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            op_reg    <= op_next;
            shamt_reg <= shamt_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, handshake outputs and operand capture.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        op_next    = op_reg;
        shamt_next = shamt_reg;
        cnt_next   = cnt_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        accept     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept = 1'b1;
                end
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                work_next = stage_out;
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                valid = 1'b1;
                // An acknowledged result frees the block in the same cycle,
                // allowing a back-to-back start without passing through IDLE.
                if (ack) begin
                    ready = 1'b1;
                    if (start) begin
                        accept = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept) begin
            work_next  = data_in;
            op_next    = op_t'(op);
            shamt_next = shamt;
            cnt_next   = CNT_W'(STAGES - 1);
            state_next = ST_SHIFT;
        end
    end

    assign data_out = work_reg;
    assign err      = valid && (op_reg == OP_RSVD);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a vector table driven through a
// scoreboard, plus hand-written back-to-back, ignored-start, hold and
// mid-shift reset sequences.
module tb_shift_seq_ctrl;
    import shift_seq_ctrl_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op_in;
    logic [W-1:0] data_in;
    logic [S-1:0] shamt;
    logic         ack;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] data_out;
    logic         err;

    shift_seq_ctrl #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op_in),
        .data_in  (data_in),
        .shamt    (shamt),
        .ack      (ack),
        .ready    (ready),
        .busy     (busy),
        .valid    (valid),
        .data_out (data_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] d;
        logic [S-1:0] sh;
        logic [W-1:0] exp;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         err;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[16];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: shift one bit at a time, shamt times.
    function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] d,
                                               input logic [S-1:0] sh);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (o)
                2'b00:   r = {r[W-2:0], 1'b0};
                2'b01:   r = {r[W-1], r[W-1:1]};
                2'b10:   r = {r[0], r[W-1:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // Wait (bounded) for ready, sampled 1 time unit after a rising edge.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", ready, 1);
    endtask

    // Present one request, push its expectation, scramble inputs after capture.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] d, input logic [S-1:0] sh,
                          input logic [W-1:0] exp, input logic e);
        sb_t item;
        wait_ready();
        start   = 1'b1;
        op_in   = o;
        data_in = d;
        shamt   = sh;
        item.d   = exp;
        item.err = e;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        start   = 1'b0;
        op_in   = 2'($urandom);
        data_in = W'($urandom);
        shamt   = S'($urandom);
        check("busy_after_accept", {29'd0, busy, ready, valid}, 32'b100);
    endtask

    // Wait (bounded) for valid; lat0 edges already elapsed since acceptance.
    task automatic collect(input string tag, input int lat0);
        int  lat;
        sb_t item;
        lat = lat0;
        while (!valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, S);
        if (valid && sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check({tag, "_data"}, data_out, item.d);
            check({tag, "_err"}, err, item.err);
            $display("txn %s: data_out=%04h err=%0b latency=%0d", tag, data_out, err, lat);
        end else begin
            check({tag, "_valid_seen"}, {31'd0, valid && sb_q.size() > 0}, 1);
        end
    endtask

    task automatic release_ack();
        ack = 1'b1;
        #1;
        check("ready_with_ack", ready, 1);
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("idle_after_ack", {30'd0, ready, valid}, 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen_valid;

        vecs[0] = '{2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0};
        vecs[1] = '{2'b01, 16'h8000, 4'd4,  16'hF800, 1'b0};
        vecs[2] = '{2'b10, 16'h1234, 4'd4,  16'h4123, 1'b0};
        vecs[3] = '{2'b00, 16'hABCD, 4'd0,  16'hABCD, 1'b0};
        vecs[4] = '{2'b11, 16'h5A5A, 4'd7,  16'h5A5A, 1'b1};
        vecs[5] = '{2'b01, 16'h7FFF, 4'd15, 16'h0000, 1'b0};
        vecs[6] = '{2'b10, 16'h0001, 4'd1,  16'h8000, 1'b0};
        vecs[7] = '{2'b00, 16'hFFFF, 4'd8,  16'hFF00, 1'b0};
        vecs[8] = '{2'b10, 16'h8001, 4'd15, 16'h0003, 1'b0};
        vecs[9] = '{2'b01, 16'hF000, 4'd8,  16'hFFF0, 1'b0};
        for (int i = 10; i < 16; i++) begin
            vecs[i].op  = 2'($urandom_range(0, 3));
            vecs[i].d   = W'($urandom);
            vecs[i].sh  = S'($urandom);
            vecs[i].exp = ref_shift(vecs[i].op, vecs[i].d, vecs[i].sh);
            vecs[i].err = (vecs[i].op == 2'b11);
        end

        rst     = 1'b1;
        start   = 1'b0;
        op_in   = 2'b00;
        data_in = '0;
        shamt   = '0;
        ack     = 1'b0;
        #12;
        check("reset_outputs", {27'd0, ready, busy, valid, err, 1'b0}, 32'b10000);
        check("reset_data_out", data_out, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            launch(vecs[i].op, vecs[i].d, vecs[i].sh, vecs[i].exp, vecs[i].err);
            collect($sformatf("vec%0d", i), 0);
            release_ack();
        end

        // Back-to-back: acknowledge and restart in the same DONE cycle.
        launch(2'b00, 16'h0001, 4'd1, 16'h0002, 1'b0);
        collect("b2b_first", 0);
        ack     = 1'b1;
        start   = 1'b1;
        op_in   = 2'b01;
        data_in = 16'hF000;
        shamt   = 4'd8;
        sb_q.push_back('{16'hFFF0, 1'b0});
        #1;
        check("b2b_ready_in_done", ready, 1);
        @(posedge clk);
        #1;
        ack   = 1'b0;
        start = 1'b0;
        data_in = 16'h1111;
        check("b2b_no_idle", {30'd0, busy, ready}, 32'b10);
        collect("b2b_second", 0);
        release_ack();

        // Start while busy is ignored; result then held for 10 cycles.
        launch(2'b10, 16'h00F0, 4'd4, 16'h000F, 1'b0);
        start   = 1'b1;
        op_in   = 2'b00;
        data_in = 16'hFFFF;
        shamt   = 4'd1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        collect("ignore_start", 2);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", i), valid, 1);
            check($sformatf("hold%0d_data", i), data_out, 16'h000F);
        end
        start = 1'b0;
        release_ack();

        // Reset in the middle of a shift discards it.
        launch(2'b00, 16'h0003, 4'd2, 16'h000C, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {28'd0, ready, busy, valid, err}, 32'b1000);
        check("midrst_data_out", data_out, 0);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid = 1'b1;
        end
        check("midrst_no_valid", seen_valid, 0);
        launch(2'b01, 16'h8001, 4'd1, 16'hC000, 1'b0);
        collect("after_rst", 0);
        release_ack();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, data width of operand and result.
REQ-002 Parameter: STAGES, 4, number of shift stages; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin a shift; sampled only when ready=1.
REQ-006 op  input  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 reserved.
REQ-007 data_in  input  WIDTH  operand; captured on start acceptance.
REQ-008 shamt  input  STAGES  shift amount 0..15; captured on start acceptance.
REQ-009 ack  input  1  consumer accepts the result; meaningful only when valid=1.
REQ-010 ready  output  1  high only in IDLE; start is accepted in the same cycle.
REQ-011 busy  output  1  high in SHIFT.
REQ-012 valid  output  1  high in DONE; result is on data_out.
REQ-013 data_out  output  WIDTH  result; stable while valid=1.
REQ-014 err  output  1  high with valid when the captured op was 11.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE; encoding is implementation-defined.
REQ-016 IDLE with start=1: capture data_in, shamt and op; set stage counter to STAGES-1; go to SHIFT.
REQ-017 SHIFT, each cycle: apply the stage of weight 2^k to the working register if shamt[k]=1, else pass it unchanged; k=counter; decrement counter.
REQ-018 SHIFT with counter=0: apply the last stage, then go to DONE.
REQ-019 Stage order: descending (8, 4, 2, 1).
REQ-020 Latency: start accepted at edge N SHALL give valid=1 after edge N+STAGES, for every shamt including 0.
REQ-021 SLL fills with zero.
REQ-022 SRA fills with bit WIDTH-1 of the stage input.
REQ-023 ROR wraps the low bits into the high bits.
REQ-024 Shifts are modulo-free: shamt=15 on WIDTH=16 is valid; no bit is lost beyond the stated fill.
REQ-025 op=11: data_out=captured data_in unshifted; err=1 for the full DONE period; the full latency still applies.
REQ-026 DONE: hold valid, data_out and err until ack=1.
REQ-027 DONE with ack=1 and start=0: go to IDLE.
REQ-028 DONE with ack=1 and start=1: capture the new operands and go directly to SHIFT.
REQ-029 In the case of REQ-028, ready SHALL also be high in that DONE cycle.
REQ-030 start while busy=1, or while in DONE with ack=0: ignored; no operand capture.
REQ-031 ack outside DONE: ignored.
REQ-032 Input changes after capture SHALL NOT affect the in-flight result.

Reset
REQ-033 rst=1 in any state, including mid-SHIFT: state=IDLE and counter=0.
REQ-034 rst=1: working register, captured op and data_out=0.
REQ-035 rst=1: ready=1, busy=0, valid=0, err=0.
REQ-036 A shift in flight at reset SHALL be discarded; no valid pulse follows.
REQ-037 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-038 Shared package: op encodings (SLL, SRA, ROR, RSVD) and state enumeration.
REQ-039 One combinational sub-module, shift_stage: inputs data, op, weight index, enable; output shifted data.
REQ-040 shift_seq_ctrl SHALL instantiate shift_stage once and reuse it every SHIFT cycle.
REQ-041 Registers: working register, captured op, captured shamt, counter, state.

Verification
REQ-042 SLL: data_in=0x0001, shamt=15 -> valid after 4 edges; data_out=0x8000, err=0.
REQ-043 SRA 0x8000, shamt=4 -> 0xF800; ROR 0x1234, shamt=4 -> 0x4123; SLL 0xABCD, shamt=0 -> 0xABCD, same 4-cycle latency.
REQ-044 op=11, data_in=0x5A5A, shamt=7 -> data_out=0x5A5A, err=1 with valid.
REQ-045 Back-to-back: in DONE assert ack=1 and start=1 (SRA 0xF000, shamt=8) -> no IDLE cycle; next valid after 4 edges with data_out=0xFFF0.
REQ-046 Assert start during SHIFT with different operands -> ignored; first result unchanged. Hold ack=0 for 10 cycles in DONE -> data_out stable, valid held.
REQ-047 Assert rst at SHIFT cycle 2 -> outputs at reset values immediately; no valid; next start yields the correct result.
